vlsu_req_sched: RTL and testbench

Request scheduler in front of the VLSU instruction port. It arbitrates up to NrReq dispatch sources (vector and matrix issue) onto the single `pe_req` handshake of the VLSU and tracks in-flight loads and stores from completion pulses. It enforces load/store memory ordering: loads and stores are never in flight together. It also caps in-flight instructions per type and prevents starvation of a blocked requester.

---
 rtl/vlsu_pkg.sv | 9 +
 rtl/rr_arb_lock.sv | 62 ++++++
 rtl/vlsu_req_sched.sv | 124 ++++++++++++
 tb/tb_vlsu_req_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_pkg.sv
// Shared constants and types for the VLSU request scheduler.
package vlsu_pkg;

  localparam int unsigned NrReqDefault    = 2;
  localparam int unsigned MaxOutstDefault = 4;

  typedef logic [$clog2(NrReqDefault)-1:0] sched_src_t;

endpackage

// File: rtl/rr_arb_lock.sv
// Round-robin arbiter with a drain lock that holds off all other sources while the
// source at the pointer waits for the opposite-type counter to drain.
module rr_arb_lock #(
  parameter int unsigned NrReq = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NrReq-1:0]         valid_i,
  input  logic [NrReq-1:0]         eligible_i,
  input  logic [NrReq-1:0]         conflict_only_i,
  input  logic                     grant_i,
  output logic [NrReq-1:0]         winner_o,
  output logic [$clog2(NrReq)-1:0] winner_idx_o
);

  localparam int unsigned SrcW = $clog2(NrReq);

  logic [SrcW-1:0] rr_q, rr_d, win_idx;
  logic            lock_q, lock_d, lock_active, found;
  int unsigned     idx;

  always_comb begin
    idx         = 0;
    found       = 1'b0;
    win_idx     = rr_q;
    // The lock only takes effect while the pointed-to source keeps its request up.
    lock_active = valid_i[rr_q] & (lock_q | conflict_only_i[rr_q]);
    if (lock_active) begin
      found = eligible_i[rr_q];
    end else begin
      for (int unsigned k = 0; k < NrReq; k++) begin
        idx = (32'(rr_q) + k) % NrReq;
        if (!found && eligible_i[idx]) begin
          found   = 1'b1;
          win_idx = SrcW'(idx);
        end
      end
    end

    winner_o = '0;
    if (found) winner_o[win_idx] = 1'b1;

    rr_d = rr_q;
    if (grant_i && found) begin
      rr_d = (32'(win_idx) == NrReq - 1) ? '0 : win_idx + SrcW'(1);
    end
    lock_d = lock_active & ~(grant_i & found);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      lock_q <= lock_d;
    end
  end

  assign winner_idx_o = win_idx;

endmodule

// File: rtl/vlsu_req_sched.sv
// Arbitrates dispatch sources onto the VLSU request port, keeping loads and stores
// from being in flight together and capping in-flight instructions per type.
module vlsu_req_sched
  import vlsu_pkg::*;
#(
  parameter int unsigned NrReq    = NrReqDefault,
  parameter int unsigned MaxOutst = MaxOutstDefault,
  parameter type         req_t    = logic,
  parameter type         cnt_t    = logic [$clog2(MaxOutst+1)-1:0]
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NrReq-1:0]         req_valid_i,
  output logic [NrReq-1:0]         req_ready_o,
  input  req_t [NrReq-1:0]         req_i,
  input  logic [NrReq-1:0]         req_is_load_i,
  output logic                     vlsu_req_valid_o,
  input  logic                     vlsu_req_ready_i,
  output req_t                     vlsu_req_o,
  output logic [$clog2(NrReq)-1:0] vlsu_src_o,
  input  logic                     ld_done_i,
  input  logic                     st_done_i,
  output cnt_t                     ld_cnt_o,
  output cnt_t                     st_cnt_o,
  output logic                     idle_o,
  output logic                     err_o
);

  localparam int unsigned SrcW = $clog2(NrReq);

  logic [NrReq-1:0] eligible, conflict_only, winner;
  logic [SrcW-1:0]  win_idx;
  logic             ld_zero, st_zero, ld_room, st_room;
  logic             can_load, accept, win_is_load;
  logic             ld_inc, ld_dec, st_inc, st_dec;

  logic             out_valid_q;
  req_t             out_req_q;
  logic [SrcW-1:0]  out_src_q;
  cnt_t             ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;
  logic             err_q, err_d;

  always_comb begin
    ld_zero       = (ld_cnt_q == '0);
    st_zero       = (st_cnt_q == '0);
    ld_room       = (ld_cnt_q < cnt_t'(MaxOutst));
    st_room       = (st_cnt_q < cnt_t'(MaxOutst));
    eligible      = '0;
    conflict_only = '0;
    for (int unsigned i = 0; i < NrReq; i++) begin
      if (req_is_load_i[i]) begin
        eligible[i]      = req_valid_i[i] & st_zero & ld_room;
        conflict_only[i] = req_valid_i[i] & ~st_zero & ld_room;
      end else begin
        eligible[i]      = req_valid_i[i] & ld_zero & st_room;
        conflict_only[i] = req_valid_i[i] & ~ld_zero & st_room;
      end
    end
  end

  rr_arb_lock #(
    .NrReq (NrReq)
  ) i_arb (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .valid_i         (req_valid_i),
    .eligible_i      (eligible),
    .conflict_only_i (conflict_only),
    .grant_i         (accept),
    .winner_o        (winner),
    .winner_idx_o    (win_idx)
  );

  always_comb begin
    can_load    = ~out_valid_q | vlsu_req_ready_i;
    req_ready_o = rst_i ? '0 : (winner & {NrReq{can_load}});
    accept      = |req_ready_o;
    win_is_load = req_is_load_i[win_idx];

    // A done pulse against an empty counter is an error and must not wrap the count.
    ld_inc = accept & win_is_load;
    st_inc = accept & ~win_is_load;
    ld_dec = ld_done_i & ~ld_zero;
    st_dec = st_done_i & ~st_zero;

    ld_cnt_d = ld_cnt_q;
    if (ld_inc && !ld_dec) ld_cnt_d = ld_cnt_q + cnt_t'(1);
    else if (!ld_inc && ld_dec) ld_cnt_d = ld_cnt_q - cnt_t'(1);
    st_cnt_d = st_cnt_q;
    if (st_inc && !st_dec) st_cnt_d = st_cnt_q + cnt_t'(1);
    else if (!st_inc && st_dec) st_cnt_d = st_cnt_q - cnt_t'(1);

    err_d = err_q | (ld_done_i & ld_zero) | (st_done_i & st_zero);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
      out_src_q   <= '0;
      ld_cnt_q    <= '0;
      st_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (can_load) out_valid_q <= accept;
      if (accept) begin
        out_req_q <= req_i[win_idx];
        out_src_q <= win_idx;
      end
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
      err_q    <= err_d;
    end
  end

  assign vlsu_req_valid_o = out_valid_q;
  assign vlsu_req_o       = out_req_q;
  assign vlsu_src_o       = out_src_q;
  assign ld_cnt_o         = ld_cnt_q;
  assign st_cnt_o         = st_cnt_q;
  assign idle_o           = ~out_valid_q & ld_zero & st_zero;
  assign err_o            = err_q;

endmodule

// File: tb/tb_vlsu_req_sched.sv
// Randomized and directed bench for vlsu_req_sched against a behavioural model.
module tb_vlsu_req_sched;

  localparam int N = 2;
  localparam int M = 4;
  typedef logic [7:0] data_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, req_is_load;
  data_t [N-1:0]    req_data;
  logic             vv, vr;
  data_t            vreq;
  logic [0:0]       vsrc;
  logic             ld_done, st_done;
  logic [2:0]       ld_cnt, st_cnt;
  logic             idle, err;

  vlsu_req_sched #(
    .NrReq    (N),
    .MaxOutst (M),
    .req_t    (data_t)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_i            (req_data),
    .req_is_load_i    (req_is_load),
    .vlsu_req_valid_o (vv),
    .vlsu_req_ready_i (vr),
    .vlsu_req_o       (vreq),
    .vlsu_src_o       (vsrc),
    .ld_done_i        (ld_done),
    .st_done_i        (st_done),
    .ld_cnt_o         (ld_cnt),
    .st_cnt_o         (st_cnt),
    .idle_o           (idle),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  int m_ld, m_st, m_rr, m_od, m_osrc;
  bit m_lock, m_err, m_ov;

  // Source-side pending requests.
  bit s_v[N];
  int s_d[N];
  bit s_ld[N];
  bit auto_regen;
  int regen_pct, ld_pct;
  logic [N-1:0] obs_ready;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit elig(input int i);
    if (!s_v[i]) return 1'b0;
    if (s_ld[i]) return (m_st == 0) && (m_ld < M);
    return (m_ld == 0) && (m_st < M);
  endfunction

  function automatic bit confl(input int i);
    if (!s_v[i]) return 1'b0;
    if (s_ld[i]) return (m_st != 0) && (m_ld < M);
    return (m_ld != 0) && (m_st < M);
  endfunction

  task automatic newreq(input int i);
    s_v[i]  = 1'b1;
    s_d[i]  = int'($urandom_range(255));
    s_ld[i] = int'($urandom_range(99)) < ld_pct;
  endtask

  task automatic set_src(input int i, input bit is_ld, input int d);
    s_v[i]  = 1'b1;
    s_ld[i] = is_ld;
    s_d[i]  = d;
  endtask

  // Called at a negedge with inputs chosen; returns at the following negedge.
  task automatic step();
    int w, idx;
    bit blocked, acc;
    logic [N-1:0] er;
    for (int i = 0; i < N; i++) begin
      req_valid[i]   = s_v[i];
      req_data[i]    = data_t'(s_d[i]);
      req_is_load[i] = s_ld[i];
    end
    #1;
    blocked = s_v[m_rr] && (m_lock || confl(m_rr));
    w = -1;
    if (blocked) begin
      if (elig(m_rr)) w = m_rr;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (w < 0 && elig(idx)) w = idx;
      end
    end
    er = '0;
    if (!rst && w >= 0 && (!m_ov || vr)) er[w] = 1'b1;

    chk("req_ready", int'(req_ready), int'(er));
    chk("vlsu_valid", int'(vv), int'(m_ov));
    if (m_ov) begin
      chk("vlsu_req", int'(vreq), m_od);
      chk("vlsu_src", int'(vsrc), m_osrc);
    end
    chk("ld_cnt", int'(ld_cnt), m_ld);
    chk("st_cnt", int'(st_cnt), m_st);
    chk("idle", int'(idle), int'(!m_ov && m_ld == 0 && m_st == 0));
    chk("err", int'(err), int'(m_err));
    obs_ready = req_ready;

    @(posedge clk);
    if (rst) begin
      m_ld = 0; m_st = 0; m_rr = 0; m_lock = 0; m_err = 0; m_ov = 0; m_od = 0; m_osrc = 0;
    end else begin
      acc    = (er != '0);
      m_lock = blocked && !(acc && w == m_rr);
      if (!m_ov || vr) begin
        m_ov = acc;
        if (acc) begin
          m_od   = s_d[w];
          m_osrc = w;
        end
      end
      if (ld_done) begin
        if (m_ld == 0) m_err = 1'b1;
        else m_ld--;
      end
      if (st_done) begin
        if (m_st == 0) m_err = 1'b1;
        else m_st--;
      end
      if (acc) begin
        if (s_ld[w]) m_ld++;
        else m_st++;
        m_rr = (w + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) if (s_v[i] && obs_ready[i]) s_v[i] = 1'b0;
    if (auto_regen) begin
      for (int i = 0; i < N; i++)
        if (!s_v[i] && int'($urandom_range(99)) < regen_pct) newreq(i);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ld_done = 1'b0;
    st_done = 1'b0;
    auto_regen = 1'b0;
    for (int i = 0; i < N; i++) s_v[i] = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pcts[5];
    pcts = '{100, 0, 50, 90, 10};
    rst = 1'b1; vr = 1'b1; ld_done = 1'b0; st_done = 1'b0;
    req_valid = '0; req_is_load = '0; req_data = '0;
    auto_regen = 1'b0; regen_pct = 100; ld_pct = 100;
    for (int i = 0; i < N; i++) begin s_v[i] = 0; s_d[i] = 0; s_ld[i] = 0; end
    m_ld = 0; m_st = 0; m_rr = 0; m_lock = 0; m_err = 0; m_ov = 0; m_od = 0; m_osrc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready_forced", int'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_vlsu_valid", int'(vv), 0);
    chk("rst_vlsu_req", int'(vreq), 0);
    chk("rst_vlsu_src", int'(vsrc), 0);
    chk("rst_ld_cnt", int'(ld_cnt), 0);
    chk("rst_st_cnt", int'(st_cnt), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_err", int'(err), 0);

    // Alternating loads up to the cap.
    vr = 1'b1; ld_pct = 100; regen_pct = 100; auto_regen = 1'b1;
    newreq(0); newreq(1);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t1_grant", int'(obs_ready), (j % 2 == 0) ? 1 : 2);
    end
    chk("t1_ld_cnt_cap", int'(ld_cnt), 4);
    step();
    chk("t1_capped", int'(obs_ready), 0);
    ld_done = 1'b1;
    step();
    chk("t1_done_lat", int'(obs_ready), 0);
    ld_done = 1'b0;
    step();
    chk("t1_resume", int'(obs_ready), 1);

    // Store waits for loads to drain.
    do_reset();
    vr = 1'b1;
    set_src(0, 1'b1, 8'h11); step();
    set_src(0, 1'b1, 8'h12); step();
    chk("t2_ld_cnt", int'(ld_cnt), 2);
    set_src(0, 1'b0, 8'h33); step();
    chk("t2_blocked", int'(obs_ready), 0);
    ld_done = 1'b1; step(); chk("t2_n", int'(obs_ready), 0);
    ld_done = 1'b0; step(); chk("t2_n1", int'(obs_ready), 0);
    step(); chk("t2_n2", int'(obs_ready), 0);
    ld_done = 1'b1; step(); chk("t2_n3", int'(obs_ready), 0);
    ld_done = 1'b0; step(); chk("t2_n4", int'(obs_ready), 1);
    chk("t2_st_cnt", int'(st_cnt), 1);
    chk("t2_ld_zero", int'(ld_cnt), 0);

    // Anti-starvation: store at the pointer blocks the load stream.
    do_reset();
    vr = 1'b1;
    set_src(0, 1'b1, 8'h21); step();
    set_src(0, 1'b1, 8'h22); step();
    set_src(0, 1'b1, 8'h23); set_src(1, 1'b0, 8'h44);
    ld_done = 1'b1; step(); chk("t3_lock_a", int'(obs_ready), 0);
    step(); chk("t3_lock_b", int'(obs_ready), 0);
    ld_done = 1'b0; step(); chk("t3_store", int'(obs_ready), 2);
    chk("t3_st_cnt", int'(st_cnt), 1);
    chk("t3_src", int'(vsrc), 1);
    step(); chk("t3_rev_lock", int'(obs_ready), 0);
    st_done = 1'b1; step(); chk("t3_rev_wait", int'(obs_ready), 0);
    st_done = 1'b0; step(); chk("t3_rr0", int'(obs_ready), 1);

    // Backpressure holds the output register.
    do_reset();
    vr = 1'b0;
    set_src(0, 1'b1, 8'h5A); step();
    chk("t4_first", int'(obs_ready), 1);
    set_src(0, 1'b1, 8'h6B);
    for (int j = 0; j < 5; j++) begin
      step();
      chk("t4_stall_ready", int'(obs_ready), 0);
      chk("t4_stall_req", int'(vreq), 8'h5A);
      chk("t4_stall_src", int'(vsrc), 0);
    end
    vr = 1'b1; step();
    chk("t4_release", int'(obs_ready), 1);
    chk("t4_next_req", int'(vreq), 8'h6B);

    // Accept and done together; error flag.
    do_reset();
    vr = 1'b1;
    set_src(0, 1'b1, 8'h01); step();
    set_src(0, 1'b1, 8'h02); ld_done = 1'b1; step();
    ld_done = 1'b0;
    chk("t5_acc_done", int'(obs_ready), 1);
    chk("t5_ld_same", int'(ld_cnt), 1);
    st_done = 1'b1; step(); st_done = 1'b0;
    chk("t5_err_set", int'(err), 1);
    chk("t5_st_zero", int'(st_cnt), 0);
    repeat (3) step();
    chk("t5_err_sticky", int'(err), 1);
    do_reset();
    chk("t5_err_clr", int'(err), 0);

    // Randomized traffic.
    auto_regen = 1'b1; regen_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      ld_pct  = pcts[(c / 200) % 5];
      vr      = int'($urandom_range(99)) < 70;
      ld_done = (m_ld > 0) && int'($urandom_range(99)) < 40;
      st_done = (m_st > 0) && int'($urandom_range(99)) < 40;
      step();
    end

    // Reset mid-stream.
    ld_done = 1'b0; st_done = 1'b0; auto_regen = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_valid", int'(vv), 0);
    chk("t6_ld_cnt", int'(ld_cnt), 0);
    chk("t6_st_cnt", int'(st_cnt), 0);
    chk("t6_idle", int'(idle), 1);
    chk("t6_err", int'(err), 0);
    vr = 1'b1;
    set_src(0, 1'b1, 8'h71); set_src(1, 1'b1, 8'h72);
    step();
    chk("t6_rr_restart", int'(obs_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
